memory_stage: RTL and testbench

- Memory-stage datapath and FSM. Sits between the memory pipeline register (input side) and the writeback pipeline register (output side).
- Turns loads and stores into a req/ack transaction on the data-memory port. Builds byte enables and store lanes, aligns and extends load data, and flags misaligned or illegal accesses.
- Drives a stall request to the hazard unit while a transaction is outstanding.
- Non-memory instructions pass through combinationally.

---
 rtl/memory_stage_if.sv | 23 ++
 rtl/memory_stage.sv | 148 ++++++++++++++
 tb/tb_memory_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// Request is held until ack; rdata is valid alongside ack on loads.
interface memory_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: turns loads/stores into a req/ack bus transaction,
// aligns load data and passes non-memory results through to writeback.
package memory_stage_pkg;
  typedef logic [6:0] opcode_t;
  typedef logic [2:0] funct3_t;
  localparam opcode_t OP_LOAD  = 7'b0000011;
  localparam opcode_t OP_STORE = 7'b0100011;
endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RCNT_LOG = 5
) (
  input  logic                clk,
  input  logic                nrst,
  input  opcode_t             in_opcode,
  input  funct3_t             in_funct3,
  input  logic [RCNT_LOG-1:0] in_rd_addr,
  input  logic [XLEN-1:0]     in_rd,
  input  logic [XLEN-1:0]     in_mem_addr,
  input  logic [XLEN-1:0]     in_mem_wr_data,
  input  logic                hazi_stall,
  memory_stage_if.master      dmem,
  output logic                hazo_stall,
  output logic                mem_fault,
  output logic [RCNT_LOG-1:0] out_rd_addr,
  output logic [XLEN-1:0]     out_rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic            req_q;
  logic            we_q;
  logic [XLEN-1:0] lbuf;

  logic            is_load;
  logic            is_store;
  logic            mem_op;
  logic            legal;
  logic            misal;
  logic            valid;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_ext;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;

  always_comb begin
    is_load  = (in_opcode == OP_LOAD);
    is_store = (in_opcode == OP_STORE);
    mem_op   = is_load | is_store;
    legal    = 1'b0;
    unique case (1'b1)
      is_load:  legal = in_funct3 inside {3'b000, 3'b001, 3'b010,
                                          3'b100, 3'b101};
      is_store: legal = in_funct3 inside {3'b000, 3'b001, 3'b010};
      default:  legal = 1'b0;
    endcase
    misal = ((in_funct3[1:0] == 2'b01) & in_mem_addr[0])
          | ((in_funct3[1:0] == 2'b10) & (|in_mem_addr[1:0]));
    mem_fault = mem_op & (~legal | misal);
    valid     = mem_op & ~mem_fault;
  end

  always_comb begin
    be    = 4'b1111;
    wdata = in_mem_wr_data;
    unique case (in_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << in_mem_addr[1:0];
        wdata = {4{in_mem_wr_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {in_mem_addr[1], 1'b0};
        wdata = {2{in_mem_wr_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = in_mem_wr_data;
      end
    endcase
  end

  always_comb begin
    ld_b   = 8'(lbuf >> {in_mem_addr[1:0], 3'b000});
    ld_h   = 16'(lbuf >> {in_mem_addr[1], 4'b0000});
    ld_ext = lbuf;
    unique case (in_funct3)
      3'b000:  ld_ext = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'b001:  ld_ext = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_b};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_ext = lbuf;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      req_q <= 1'b0;
      we_q  <= 1'b0;
      lbuf  <= '0;
    end else begin
      unique case (state)
        IDLE: if (valid) begin
          state <= REQ;
          req_q <= 1'b1;
          we_q  <= is_store;
        end
        REQ: if (dmem.ack) begin
          state <= DONE;
          req_q <= 1'b0;
          we_q  <= 1'b0;
          lbuf  <= dmem.rdata;
        end
        DONE: if (!hazi_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = {in_mem_addr[XLEN-1:2], 2'b00};
  assign dmem.be    = be;
  assign dmem.wdata = wdata;

  assign hazo_stall = valid & (state != DONE);

  // Only a completed load or a non-memory op ever names a register
  always_comb begin
    out_rd_addr = '0;
    out_rd      = '0;
    if (!mem_op) begin
      out_rd_addr = in_rd_addr;
      out_rd      = in_rd;
    end else if (valid & is_load & (state == DONE)) begin
      out_rd_addr = in_rd_addr;
      out_rd      = ld_ext;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomised self-checking bench for memory_stage with a
// transaction-level model of bus timing and load/store lanes.
module tb_memory_stage;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_ADD   = 7'h33;
  localparam logic [6:0] OP_IMM   = 7'h13;

  logic        clk = 1'b0;
  logic        nrst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rd_addr;
  logic [31:0] rd;
  logic [31:0] maddr;
  logic [31:0] wd;
  logic        hazi;
  logic        hazo;
  logic        fault;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd;

  int total = 0;
  int bad   = 0;

  memory_stage_if #(.XLEN(32)) dmem ();

  memory_stage #(.XLEN(32), .RCNT_LOG(5)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .in_opcode      (opcode),
    .in_funct3      (f3),
    .in_rd_addr     (rd_addr),
    .in_rd          (rd),
    .in_mem_addr    (maddr),
    .in_mem_wr_data (wd),
    .hazi_stall     (hazi),
    .dmem           (dmem),
    .hazo_stall     (hazo),
    .mem_fault      (fault),
    .out_rd_addr    (o_rd_addr),
    .out_rd         (o_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_be(input logic [2:0] f,
                                      input logic [31:0] a);
    int sz;
    sz = 1 << f[1:0];
    if (sz > 4) sz = 4;
    return 4'(((1 << sz) - 1) << (a % 4 / sz * sz));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f,
                                          input logic [31:0] d);
    case (f[1:0])
      2'b00:   return (d & 32'hFF) * 32'h01010101;
      2'b01:   return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] v;
    case (f)
      3'b000, 3'b100: begin
        v = (r >> (8 * (a % 4))) & 32'hFF;
        if (f == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (r >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        if (f == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = r;
    endcase
    return v;
  endfunction

  task automatic nop();
    opcode  = OP_IMM;
    f3      = 3'b000;
    rd_addr = 5'd0;
    rd      = 32'd0;
    maddr   = 32'd0;
    wd      = 32'd0;
  endtask

  // Runs one legal memory op from IDLE; call at posedge+1.
  task automatic do_mem(input logic [6:0] op, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rda, input int waits,
                        input logic [31:0] rdat, input int hold,
                        input string tag);
    int nreq = 0;
    int nstall = 0;
    bit done = 0;
    bit ld;
    logic [31:0] exp_rd;
    ld = (op == OP_LOAD);
    exp_rd = m_load(f, a, rdat);
    opcode = op; f3 = f; maddr = a; wd = d;
    rd_addr = rda; rd = $urandom;
    dmem.rdata = rdat; dmem.ack = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      #1;
      if (hazo) nstall++;
      if (dmem.req) begin
        nreq++;
        total++;
        if (dmem.addr !== {a[31:2], 2'b00}) begin
          bad++;
          $display("FAIL %s addr got=%h exp=%h", tag, dmem.addr,
                   {a[31:2], 2'b00});
        end
        total++;
        if (dmem.be !== m_be(f, a)) begin
          bad++;
          $display("FAIL %s be got=%b exp=%b", tag, dmem.be, m_be(f, a));
        end
        total++;
        if (dmem.we !== !ld) begin
          bad++;
          $display("FAIL %s we got=%b exp=%b", tag, dmem.we, !ld);
        end
        if (!ld) begin
          total++;
          if (dmem.wdata !== m_wdata(f, d)) begin
            bad++;
            $display("FAIL %s wdata got=%h exp=%h", tag, dmem.wdata,
                     m_wdata(f, d));
          end
        end
        dmem.ack = (nreq == waits + 1);
      end
      if (!hazo) begin
        done = 1;
        total++;
        if (o_rd_addr !== (ld ? rda : 5'd0)) begin
          bad++;
          $display("FAIL %s done_rd_addr got=%0d exp=%0d", tag,
                   o_rd_addr, ld ? rda : 5'd0);
        end
        if (ld && rda != 0) begin
          total++;
          if (o_rd !== exp_rd) begin
            bad++;
            $display("FAIL %s done_rd got=%h exp=%h", tag, o_rd, exp_rd);
          end
        end
        if (hold > 0) begin
          hazi = 1'b1;
          repeat (hold) begin
            @(posedge clk); #1;
            if (dmem.req) nreq++;
            total++;
            if (hazo !== 1'b0 || o_rd_addr !== rda || o_rd !== exp_rd) begin
              bad++;
              $display("FAIL %s hold_done got=%b/%0d/%h exp=0/%0d/%h", tag,
                       hazo, o_rd_addr, o_rd, rda, exp_rd);
            end
          end
          hazi = 1'b0;
        end
      end else begin
        total++;
        if (o_rd_addr !== 5'd0) begin
          bad++;
          $display("FAIL %s busy_rd_addr got=%0d exp=0", tag, o_rd_addr);
        end
      end
      @(posedge clk); #1;
      dmem.ack = 1'b0;
      if (done) nop();
    end
    total++;
    if (!done || nstall != waits + 2 || nreq != waits + 1) begin
      bad++;
      $display("FAIL %s timing got=done%0d/stall%0d/req%0d exp=1/%0d/%0d",
               tag, done, nstall, nreq, waits + 2, waits + 1);
    end
    #1;
    total++;
    if (dmem.req !== 1'b0) begin
      bad++;
      $display("FAIL %s reissue got=%b exp=0", tag, dmem.req);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; hazi = 1'b0; dmem.ack = 1'b0; dmem.rdata = '0;
    nop();
    #3;
    total++;
    if (dmem.req !== 1'b0 || dmem.we !== 1'b0 || hazo !== 1'b0) begin
      bad++;
      $display("FAIL reset req/we/stall got=%b%b%b exp=000",
               dmem.req, dmem.we, hazo);
    end
    opcode = OP_LOAD; f3 = 3'b010; rd_addr = 5'd9; maddr = 32'h40;
    #1;
    total++;
    if (o_rd_addr !== 5'd0) begin
      bad++;
      $display("FAIL reset_load_rd_addr got=%0d exp=0", o_rd_addr);
    end
    nop();
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word();
    do_mem(OP_LOAD, 3'b010, 32'h100, 32'h0, 5'd3, 2,
           32'hDEADBEEF, 0, "lw");
  endtask

  task automatic test_load_ext();
    do_mem(OP_LOAD, 3'b000, 32'h103, 0, 5'd4, 0, 32'h80123456, 0, "lb");
    do_mem(OP_LOAD, 3'b100, 32'h103, 0, 5'd6, 1, 32'h80123456, 0, "lbu");
    do_mem(OP_LOAD, 3'b101, 32'h102, 0, 5'd7, 0, 32'h80123456, 0, "lhu");
    do_mem(OP_LOAD, 3'b001, 32'h102, 0, 5'd8, 0, 32'h80123456, 0, "lh");
  endtask

  task automatic test_store();
    do_mem(OP_STORE, 3'b001, 32'h202, 32'h1234ABCD, 5'd10, 0,
           32'h0, 0, "sh");
    do_mem(OP_STORE, 3'b000, 32'h301, 32'h000000A5, 5'd11, 1,
           32'h0, 0, "sb");
  endtask

  task automatic test_fault();
    logic [2:0]  fl [6] = '{3'b010, 3'b011, 3'b001, 3'b010, 3'b001, 3'b100};
    logic [31:0] al [6] = '{32'h101, 32'h100, 32'h103, 32'h102,
                            32'h101, 32'h100};
    logic [6:0]  ol [6] = '{OP_LOAD, OP_LOAD, OP_LOAD, OP_STORE,
                            OP_STORE, OP_STORE};
    for (int i = 0; i < 6; i++) begin
      opcode = ol[i]; f3 = fl[i]; maddr = al[i];
      rd_addr = 5'd12; wd = $urandom;
      repeat (3) begin
        #1;
        total++;
        if (fault !== 1'b1 || dmem.req !== 1'b0 || hazo !== 1'b0
            || o_rd_addr !== 5'd0) begin
          bad++;
          $display("FAIL fault%0d got=f%b r%b s%b a%0d exp=f1 r0 s0 a0",
                   i, fault, dmem.req, hazo, o_rd_addr);
        end
        @(posedge clk);
      end
    end
    nop();
    #1;
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL fault_clear got=%b exp=0", fault);
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 8; i++) begin
      opcode = (i == 0) ? OP_ADD : 7'(($urandom % 2) ? OP_ADD : OP_IMM);
      rd_addr = (i == 0) ? 5'd5 : 5'($urandom);
      rd = (i == 0) ? 32'd7 : $urandom;
      maddr = $urandom; f3 = 3'($urandom);
      dmem.ack = 1'($urandom);
      #1;
      total++;
      if (o_rd_addr !== rd_addr || o_rd !== rd || hazo !== 1'b0
          || fault !== 1'b0) begin
        bad++;
        $display("FAIL pass%0d got=%0d/%h/%b exp=%0d/%h/0", i,
                 o_rd_addr, o_rd, hazo, rd_addr, rd);
      end
      @(posedge clk); #1;
      total++;
      if (dmem.req !== 1'b0) begin
        bad++;
        $display("FAIL pass%0d_req got=%b exp=0", i, dmem.req);
      end
    end
    dmem.ack = 1'b0;
    nop();
  endtask

  task automatic test_reset_mid();
    opcode = OP_LOAD; f3 = 3'b010; maddr = 32'h100; rd_addr = 5'd13;
    dmem.rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    total++;
    if (dmem.req !== 1'b1) begin
      bad++;
      $display("FAIL rmid_req got=%b exp=1", dmem.req);
    end
    #2 nrst = 1'b0;
    #1;
    total++;
    if (dmem.req !== 1'b0 || hazo !== 1'b1) begin
      bad++;
      $display("FAIL rmid_drop got=%b/%b exp=0/1", dmem.req, hazo);
    end
    @(negedge clk); nrst = 1'b1;
    #1;
    total++;
    if (dmem.req !== 1'b0) begin
      bad++;
      $display("FAIL rmid_idle got=%b exp=0", dmem.req);
    end
    @(posedge clk); #1;
    total++;
    if (dmem.req !== 1'b1) begin
      bad++;
      $display("FAIL rmid_reissue got=%b exp=1", dmem.req);
    end
    dmem.ack = 1'b1;
    @(posedge clk); #1;
    dmem.ack = 1'b0;
    total++;
    if (o_rd_addr !== 5'd13 || o_rd !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL rmid_done got=%0d/%h exp=13/0badf00d", o_rd_addr, o_rd);
    end
    @(posedge clk); #1;
    nop();
    @(posedge clk); #1;
  endtask

  task automatic test_hazi_stall();
    do_mem(OP_LOAD, 3'b010, 32'h180, 0, 5'd14, 0, 32'hCAFEF00D, 3, "hold");
  endtask

  task automatic test_random();
    logic [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 40; i++) begin
      bit st;
      logic [2:0] f;
      logic [31:0] a;
      st = 1'($urandom);
      f = st ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      a = $urandom;
      if (f[1:0] == 2'b01) a[0] = 1'b0;
      if (f[1:0] == 2'b10) a[1:0] = 2'b00;
      do_mem(st ? OP_STORE : OP_LOAD, f, a, $urandom,
             5'($urandom), $urandom_range(0, 3), $urandom, 0, "rnd");
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_word();
    test_load_ext();
    test_store();
    test_fault();
    test_reset_mid();
    test_hazi_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
